// File: rtl/window3x3_if.sv
// Pixel-stream / window bundle for window3x3_gen.
//   master: pixel source; drives pix_in, pix_valid, sof and observes the window.
//   slave : window generator; consumes the stream and drives p0..p8,
//           win_valid, win_x, win_y, frame_end.
interface window3x3_if #(
  parameter int bit_width = 8,
  parameter int cnt_width = 10
);
  logic [bit_width-1:0] pix_in;
  logic                 pix_valid;
  logic                 sof;
  logic [bit_width-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic                 win_valid;
  logic [cnt_width-1:0] win_x;
  logic [cnt_width-1:0] win_y;
  logic                 frame_end;

  modport master (
    output pix_in, pix_valid, sof,
    input  p0, p1, p2, p3, p4, p5, p6, p7, p8,
    input  win_valid, win_x, win_y, frame_end
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output p0, p1, p2, p3, p4, p5, p6, p7, p8,
    output win_valid, win_x, win_y, frame_end
  );
endinterface

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator.
// Accepts a raster pixel stream, keeps the two previous lines in line buffers
// and presents the 3x3 window (p0..p8, row-major, oldest row first) with a
// one-cycle win_valid strobe for every pixel whose neighbourhood lies fully
// inside the frame.
// Ports:
//   clk   - pixel clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - window3x3_if.slave: pix_in/pix_valid/sof in;
//           p0..p8, win_valid, win_x, win_y, frame_end out (all registered)
module window3x3_gen #(
  parameter int bit_width  = 8,
  parameter int img_width  = 640,
  parameter int img_height = 480,
  parameter int cnt_width  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  window3x3_if.slave  bus
);

  localparam int addr_w = (img_width > 1) ? $clog2(img_width) : 1;
  localparam logic [cnt_width-1:0] col_last = cnt_width'(img_width - 1);
  localparam logic [cnt_width-1:0] row_last = cnt_width'(img_height - 1);
  localparam logic [cnt_width-1:0] cnt_one  = cnt_width'(1);
  localparam logic [cnt_width-1:0] cnt_two  = cnt_width'(2);

  logic [cnt_width-1:0] col, row;
  logic [cnt_width-1:0] cur_x, cur_y;
  logic [addr_w-1:0]    addr;
  logic                 win_hit;
  logic                 last_pix;

  logic [bit_width-1:0] lb_a [img_width];
  logic [bit_width-1:0] lb_b [img_width];
  logic [bit_width-1:0] rd_a, rd_b;

  logic [bit_width-1:0] win [9];

  // sof forces the current pixel to (0,0) regardless of the counters, so the
  // position of the pixel being accepted is resolved here once and shared.
  always_comb begin
    cur_x    = bus.sof ? '0 : col;
    cur_y    = bus.sof ? '0 : row;
    addr     = cur_x[addr_w-1:0];
    rd_a     = lb_a[addr];
    rd_b     = lb_b[addr];
    win_hit  = (cur_x >= cnt_two) && (cur_y >= cnt_two);
    last_pix = (cur_x == col_last) && (cur_y == row_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.pix_valid) begin
      if (cur_x == col_last) begin
        col <= '0;
        row <= (cur_y == row_last) ? '0 : cur_y + cnt_one;
      end else begin
        col <= cur_x + cnt_one;
        row <= cur_y;
      end
    end
  end

  // Line buffers are not reset; a window needs y>=2 since the last
  // sof/reset, by which point both rows read here have been rewritten.
  always_ff @(posedge clk) begin
    if (bus.pix_valid) begin
      lb_a[addr] <= rd_b;
      lb_b[addr] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 9; i++) win[i] <= '0;
      bus.win_valid <= 1'b0;
      bus.frame_end <= 1'b0;
      bus.win_x     <= '0;
      bus.win_y     <= '0;
    end else begin
      bus.win_valid <= 1'b0;
      bus.frame_end <= 1'b0;
      if (bus.pix_valid) begin
        // left column <- middle, middle <- right, right <- new column
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= rd_a;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= rd_b;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= bus.pix_in;
        bus.win_valid <= win_hit;
        bus.frame_end <= win_hit && last_pix;
        if (win_hit) begin
          bus.win_x <= cur_x - cnt_one;
          bus.win_y <= cur_y - cnt_one;
        end
      end
    end
  end

  assign bus.p0 = win[0];
  assign bus.p1 = win[1];
  assign bus.p2 = win[2];
  assign bus.p3 = win[3];
  assign bus.p4 = win[4];
  assign bus.p5 = win[5];
  assign bus.p6 = win[6];
  assign bus.p7 = win[7];
  assign bus.p8 = win[8];

endmodule

// File: doc/window3x3_gen.md
# window3x3_gen

Streaming 3x3 neighbourhood generator feeding the median filter stage in the VGA image-processing path. It accepts a raster pixel stream one pixel per valid cycle and buffers the two previous image lines in internal line buffers. For every input pixel whose 3x3 neighbourhood lies fully inside the frame, it presents the nine window pixels p0..p8 with a one-cycle valid strobe, ready for direct connection to the median inputs. Border pixels (first/last row and column) produce no window.

## Interface
- bit_width, 8, pixel width in bits
- img_width, 640, active pixels per line
- img_height, 480, active lines per frame
- cnt_width, 10, width of column/row counters and coordinate outputs; must hold img_width-1 and img_height-1
- clk  input  1  pixel clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- pix_in  input  bit_width  incoming pixel, raster order
- pix_valid  input  1  pix_in is accepted on this edge when high
- sof  input  1  start of frame; sampled only when pix_valid=1; marks the pixel as (col 0, row 0)
- p0..p8  output  bit_width each  window, row-major: p0 p1 p2 = row y-2, p3 p4 p5 = row y-1, p6 p7 p8 = row y; left to right = columns x-2, x-1, x
- win_valid  output  1  one-cycle strobe; p0..p8, win_x, win_y are valid
- win_x  output  cnt_width  column of the window centre (x-1)
- win_y  output  cnt_width  row of the window centre (y-1)
- frame_end  output  1  high with the final win_valid of a frame (centre at img_width-2, img_height-2)

## Operation
- col and row counters track the position (x, y) of the next accepted pixel. Both reset to 0.
- On an accepted pixel with sof=1: the pixel is treated as (0,0), overriding the counters. Afterwards col=1, row=0.
- Counter stepping on each accepted pixel:
  - col increments.
  - At col=img_width-1, col wraps to 0 and row increments.
  - At (img_width-1, img_height-1), both wrap to 0 without sof.
- Two line buffers, each img_width deep, addressed by col:
  - lb_a holds row y-2 and lb_b holds row y-1.
  - On an accepted pixel at column x: read lb_a[x] and lb_b[x] first.
  - Then write lb_a[x] <= old lb_b[x] and lb_b[x] <= pix_in (read-before-write on the same address).
- Window registers form a 3-column shift:
  - On each accepted pixel, the right column {p2, p5, p8} takes {lb_a[x], lb_b[x], pix_in}.
  - The middle column takes the old right column, and the left column takes the old middle column.
- win_valid is asserted on the edge after acceptance when the accepted pixel had x>=2 and y>=2.
  - win_x=x-1, win_y=y-1.
  - frame_end=1 when x=img_width-1 and y=img_height-1.
- Cycles with pix_valid=0:
  - No counter, buffer or window change.
  - win_valid=0 and frame_end=0.
  - p*, win_x and win_y hold their values.
- Line buffer contents are not reset. Stale data is never exposed because win_valid requires y>=2 relative to the last sof/reset.
- Counts per frame: (img_width-2)*(img_height-2) windows, exactly one frame_end.

## Timing
- Reset values: p0..p8=0, win_valid=0, win_x=0, win_y=0, frame_end=0; col=0, row=0.
- Latency: an accepted pixel at edge N appears as p8 with win_valid after edge N (visible in cycle N+1). All outputs are registered.
- Throughput: one pixel per clock, no backpressure.
- win_valid and frame_end are single-cycle pulses; back-to-back pulses are allowed on consecutive accepted pixels.
- Reset mid-frame: outputs clear immediately. The next accepted pixel is (0,0); no window appears until row 2 of the new count.
- sof mid-frame: resynchronises identically to reset, except that outputs are not cleared. A window pending from the previous cycle still pulses normally.
- Simultaneous sof with the counter wrap: sof takes priority; the result is the same (0,0).

## Test plan
- Frame of 4x4 (img_width=4, img_height=4), pixel = 4*row+col, continuous valid, sof on the first pixel. Required response:
  - Exactly 4 win_valid pulses.
  - First pulse: p0..p8 = 0,1,2,4,5,6,8,9,10, win_x=1, win_y=1. Median stage output is 5.
  - Last pulse: p = 5,6,7,9,10,11,13,14,15, win_x=2, win_y=2, frame_end=1.
- Same frame with pix_valid deasserted 3 cycles between every pixel. Required response: identical window sequence; win_valid never high during gaps; outputs held during gaps.
- Two consecutive 4x4 frames without a second sof. Required response: second frame yields the same 4 windows using frame-2 data, and frame_end pulses twice in total.
- sof asserted at pixel (1,2) of a 4x4 frame, then a fresh ramp. Required response: no window until the new row 2; first window after resync is 0,1,2,4,5,6,8,9,10.
- rst_n pulsed low mid-row 3. Required response: all outputs 0 asynchronously. The restarted frame yields exactly 4 windows with correct values and no stale rows.
- Default 640x480 with random pixels vs. a software model. Required response: 638*478 windows, all nine values and coordinates match, and frame_end occurs exactly once at (638, 478).
